// File: rtl/fir_xifu_ringfile.sv
`default_nettype none
// ============================================================================
// fir_xifu_ringfile : XIFU register file with a run-time circular ring window
//                     that behaves as a FIR sample delay line.
// Revision          : 1.0
// ============================================================================
module fir_xifu_ringfile #(
  parameter int NB_REGS    = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IW        = $clog2(NB_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  input  logic [IW-1:0]         cfg_base_i,
  input  logic [IW:0]           cfg_len_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [4:0]            rd_i,
  output logic [DATA_WIDTH-1:0] op_a_o,
  output logic [DATA_WIDTH-1:0] op_b_o,
  output logic [DATA_WIDTH-1:0] op_c_o,
  input  logic                  wb_write_i,
  input  logic                  wb_push_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  output logic                  ring_en_o,
  output logic [IW-1:0]         head_o,
  output logic [IW:0]           fill_o,
  output logic                  cfg_err_o
);

  logic [DATA_WIDTH-1:0] regs_q [NB_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NB_REGS];
  logic [IW-1:0]         base_q, base_d, head_q, head_d;
  logic [IW:0]           len_q, len_d, fill_q, fill_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [IW-1:0] rs1_phys, rs2_phys, rd_phys, wr_phys, last_log;
  logic          ring_push, cfg_ok;
  logic [IW+1:0] cfg_end;

  // Rotated window lookup; s stays below 2*len so one conditional subtract suffices.
  function automatic logic [IW-1:0] phys(input logic [IW-1:0] r,
                                         input logic [IW-1:0] base,
                                         input logic [IW:0]   len,
                                         input logic [IW-1:0] head);
    logic [IW:0] rw, off, s;
    rw   = {1'b0, r};
    off  = '0;
    s    = '0;
    phys = r;
    if ((len != '0) && (rw >= {1'b0, base}) && (rw < ({1'b0, base} + len))) begin
      off = rw - {1'b0, base};
      s   = off + {1'b0, head};
      if (s >= len) s = s - len;
      phys = base + s[IW-1:0];
    end
  endfunction

  generate
    if (IW < 5) begin : g_unused_idx
      logic unused_idx_hi;
      assign unused_idx_hi = ^{rs1_i[4:IW], rs2_i[4:IW], rd_i[4:IW], wb_rd_i[4:IW]};
    end
  endgenerate

  always_comb begin
    ring_push = wb_write_i && wb_push_i && (len_q != '0);
    // base+len never exceeds NB_REGS, so the IW-bit wrap yields the true last index.
    last_log  = base_q + len_q[IW-1:0] - IW'(1);
    rs1_phys  = phys(rs1_i[IW-1:0], base_q, len_q, head_q);
    rs2_phys  = phys(rs2_i[IW-1:0], base_q, len_q, head_q);
    rd_phys   = phys(rd_i[IW-1:0], base_q, len_q, head_q);
    wr_phys   = ring_push ? phys(last_log, base_q, len_q, head_q)
                          : phys(wb_rd_i[IW-1:0], base_q, len_q, head_q);
    cfg_end   = {2'b00, cfg_base_i} + {1'b0, cfg_len_i};
    cfg_ok    = (cfg_end <= (IW+2)'(NB_REGS));
  end

  always_comb begin
    op_a_o = (wb_write_i && (wr_phys == rs1_phys)) ? wb_result_i : regs_q[rs1_phys];
    op_b_o = (wb_write_i && (wr_phys == rs2_phys)) ? wb_result_i : regs_q[rs2_phys];
    op_c_o = (wb_write_i && (wr_phys == rd_phys))  ? wb_result_i : regs_q[rd_phys];
  end

  always_comb begin
    regs_d    = regs_q;
    base_d    = base_q;
    len_d     = len_q;
    head_d    = head_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;

    if (wb_write_i) regs_d[wr_phys] = wb_result_i;

    if (ring_push) begin
      head_d = (head_q == '0) ? (len_q[IW-1:0] - IW'(1)) : (head_q - IW'(1));
      fill_d = (fill_q >= len_q) ? len_q : (fill_q + (IW+1)'(1));
    end

    // An accepted configuration wins over the push's pointer update.
    if (cfg_valid_i) begin
      if (cfg_ok) begin
        base_d = cfg_base_i;
        len_d  = cfg_len_i;
        head_d = '0;
        fill_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_REGS; i++) regs_q[i] <= '0;
      base_q    <= '0;
      len_q     <= '0;
      head_q    <= '0;
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      base_q    <= base_d;
      len_q     <= len_d;
      head_q    <= head_d;
      fill_q    <= fill_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign ring_en_o = (len_q != '0);
  assign head_o    = head_q;
  assign fill_o    = fill_q;
  assign cfg_err_o = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ringfile.sv
`default_nettype none
// ============================================================================
// tb_fir_xifu_ringfile : scoreboard bench for the ring-window register file.
// Revision             : 1.0
// ============================================================================
module tb_fir_xifu_ringfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [2:0]  cfg_base;
  logic [3:0]  cfg_len;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] op_a, op_b, op_c;
  logic        wb_write, wb_push;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ring_en;
  logic [2:0]  head;
  logic [3:0]  fill;
  logic        cfg_err;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_xifu_ringfile #(.NB_REGS(8), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .op_a_o(op_a), .op_b_o(op_b), .op_c_o(op_c),
    .wb_write_i(wb_write), .wb_push_i(wb_push), .wb_rd_i(wb_rd), .wb_result_i(wb_result),
    .ring_en_o(ring_en), .head_o(head), .fill_o(fill), .cfg_err_o(cfg_err)
  );

  task automatic idle();
    cfg_valid = 1'b0; cfg_base = '0; cfg_len = '0;
    wb_write = 1'b0; wb_push = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic do_push(input logic [31:0] v);
    @(negedge clk);
    wb_write = 1'b1; wb_push = 1'b1; wb_rd = 5'($urandom); wb_result = v;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_cfg(input logic [2:0] b, input logic [3:0] l);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_base = b; cfg_len = l;
    @(posedge clk); #1;
    idle();
  endtask

  // Logical index with random junk in the ignored upper bits.
  function automatic logic [4:0] lidx(input int r);
    return {2'($urandom), 3'(r)};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_valid = 1'($urandom); cfg_base = 3'($urandom); cfg_len = 4'($urandom);
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    wb_write = 1'b0; wb_push = 1'($urandom); wb_rd = 5'($urandom); wb_result = $urandom;
    #1;
    checks++;
    if ({op_a, op_b, op_c} !== 96'h0) begin
      errors++; $display("FAIL reset_ops: got %h %h %h want 0", op_a, op_b, op_c);
    end
    checks++;
    if ({ring_en, head, fill, cfg_err} !== 9'h0) begin
      errors++; $display("FAIL reset_state: ring_en=%b head=%0d fill=%0d cfg_err=%b want 0", ring_en, head, fill, cfg_err);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) exp_q.push_back(32'h0);
    for (int r = 0; r < 8; r++) begin
      rs1 = lidx(r); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (op_a !== exp_v) begin
        errors++; $display("FAIL reset_read x%0d: got %h want %h", r, op_a, exp_v);
      end
    end
  endtask

  task automatic test_flat_bypass();
    @(negedge clk);
    wb_write = 1'b1; wb_push = 1'b0; wb_rd = lidx(3); wb_result = 32'hDEADBEEF;
    rs1 = lidx(3); rs2 = lidx(2); rd = lidx(3);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0); exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (op_a !== exp_v) begin errors++; $display("FAIL bypass_a: got %h want %h", op_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (op_b !== exp_v) begin errors++; $display("FAIL bypass_b: got %h want %h", op_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (op_c !== exp_v) begin errors++; $display("FAIL bypass_c: got %h want %h", op_c, exp_v); end
    @(posedge clk); #1;
    idle();
    rs1 = lidx(3);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (op_a !== exp_v) begin errors++; $display("FAIL flat_hold: got %h want %h", op_a, exp_v); end
    // Seed x0..x2 so later ring tests can confirm they stay untouched.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      wb_write = 1'b1; wb_rd = lidx(r); wb_result = 32'hA0 + 32'(r);
      @(posedge clk); #1;
      idle();
    end
  endtask

  task automatic check_window(input string tag, input logic [31:0] e4, input logic [31:0] e5,
                              input logic [31:0] e6, input logic [31:0] e7);
    logic [31:0] e[8];
    e = '{32'hA0, 32'hA1, 32'hA2, 32'hDEADBEEF, e4, e5, e6, e7};
    for (int r = 0; r < 8; r++) exp_q.push_back(e[r]);
    for (int r = 0; r < 8; r++) begin
      rs2 = lidx(r); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (op_b !== exp_v) begin
        errors++; $display("FAIL %s x%0d: got %h want %h", tag, r, op_b, exp_v);
      end
    end
  endtask

  task automatic test_ring_fill();
    do_cfg(3'd4, 4'd4);
    checks++;
    if ({ring_en, head, fill} !== {1'b1, 3'd0, 4'd0}) begin
      errors++; $display("FAIL cfg_accept: ring_en=%b head=%0d fill=%0d want 1 0 0", ring_en, head, fill);
    end
    do_push(32'h10);
    checks++;
    if ({head, fill} !== {3'd3, 4'd1}) begin
      errors++; $display("FAIL first_push: head=%0d fill=%0d want 3 1", head, fill);
    end
    do_push(32'h20); do_push(32'h30); do_push(32'h40);
    checks++;
    if ({head, fill} !== {3'd0, 4'd4}) begin
      errors++; $display("FAIL ring_full: head=%0d fill=%0d want 0 4", head, fill);
    end
    check_window("ring_fill", 32'h40, 32'h30, 32'h20, 32'h10);
  endtask

  task automatic test_wrap_saturate();
    @(negedge clk);
    wb_write = 1'b1; wb_push = 1'b1; wb_rd = lidx(4); wb_result = 32'h50;
    rs1 = lidx(7); rs2 = lidx(4);
    exp_q.push_back(32'h50); exp_q.push_back(32'h40);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (op_a !== exp_v) begin errors++; $display("FAIL push_bypass_hit: got %h want %h", op_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (op_b !== exp_v) begin errors++; $display("FAIL push_bypass_miss: got %h want %h", op_b, exp_v); end
    @(posedge clk); #1;
    idle();
    checks++;
    if ({head, fill} !== {3'd3, 4'd4}) begin
      errors++; $display("FAIL wrap_ptr: head=%0d fill=%0d want 3 4", head, fill);
    end
    check_window("wrap", 32'h50, 32'h40, 32'h30, 32'h20);
  endtask

  task automatic test_rejected_cfg();
    do_cfg(3'd6, 4'd4);
    checks++;
    if ({cfg_err, ring_en, head, fill} !== {1'b1, 1'b1, 3'd3, 4'd4}) begin
      errors++; $display("FAIL cfg_reject: err=%b ring_en=%b head=%0d fill=%0d want 1 1 3 4", cfg_err, ring_en, head, fill);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
    do_push(32'h60);
    checks++;
    if ({head, fill} !== {3'd2, 4'd4}) begin
      errors++; $display("FAIL reject_push: head=%0d fill=%0d want 2 4", head, fill);
    end
    check_window("after_reject", 32'h60, 32'h50, 32'h40, 32'h30);
  endtask

  task automatic test_cfg_push_collision();
    @(negedge clk);
    wb_write = 1'b1; wb_push = 1'b1; wb_rd = lidx(0); wb_result = 32'h99;
    cfg_valid = 1'b1; cfg_base = 3'd0; cfg_len = 4'd2;
    @(posedge clk); #1;
    idle();
    checks++;
    if ({ring_en, head, fill, cfg_err} !== {1'b1, 3'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL collide_ptr: ring_en=%b head=%0d fill=%0d err=%b want 1 0 0 0", ring_en, head, fill, cfg_err);
    end
    // Old mapping (head 2) sent the push to physical 5; x4..x7 are now flat.
    check_window("collide", 32'h40, 32'h99, 32'h60, 32'h50);
  endtask

  task automatic test_ring_disabled_push();
    do_cfg(3'd0, 4'd0);
    @(negedge clk);
    wb_write = 1'b1; wb_push = 1'b1; wb_rd = lidx(6); wb_result = 32'h77;
    @(posedge clk); #1;
    idle();
    rs1 = lidx(6);
    exp_q.push_back(32'h77);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (op_a !== exp_v) begin errors++; $display("FAIL disabled_push_data: got %h want %h", op_a, exp_v); end
    checks++;
    if ({ring_en, head, fill} !== 8'h0) begin
      errors++; $display("FAIL disabled_push_ptr: ring_en=%b head=%0d fill=%0d want 0 0 0", ring_en, head, fill);
    end
  endtask

  task automatic test_async_reset();
    do_cfg(3'd2, 4'd3);
    do_push(32'h5A);
    checks++;
    if ({head, fill} !== {3'd2, 4'd1}) begin
      errors++; $display("FAIL pre_reset_ptr: head=%0d fill=%0d want 2 1", head, fill);
    end
    rs1 = lidx(2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ring_en, head, fill, op_a} !== 40'h0) begin
      errors++; $display("FAIL async_reset: ring_en=%b head=%0d fill=%0d op_a=%h want 0", ring_en, head, fill, op_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    rs1 = '0; rs2 = '0; rd = '0;
    test_reset();
    test_flat_bypass();
    test_ring_fill();
    test_wrap_saturate();
    test_rejected_cfg();
    test_cfg_push_collision();
    test_ring_disabled_push();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
